// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port integer register file with byte-enabled
// writeback, x0 tied to zero, write-to-read bypass and a pending-write
// scoreboard with a registered busy count for issue-stage hazard checks.

// One read port: selects the stored entry and overlays a same-cycle write.
module regfile_mp_sb_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs,
  input  logic [NUM_REGS-1:0]                   busy,
  input  logic                                  wr_ok,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic [DATA_WIDTH/8-1:0]               wr_be,
  output logic [DATA_WIDTH-1:0]                 data,
  output logic                                  bsy
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] stored;
  logic                  stored_bsy;

  // Storage lookup; x0 and out-of-range addresses fall through to zero/idle.
  always_comb begin
    stored     = '0;
    stored_bsy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        stored     = regs[i];
        stored_bsy = busy[i];
      end
    end
  end

  // Bypass: a qualified write to this address is merged in and clears busy.
  always_comb begin
    data = stored;
    bsy  = stored_bsy;
    if (wr_ok && (wr_addr == addr)) begin
      bsy = 1'b0;
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) data[8*k +: 8] = wr_data[8*k +: 8];
      end
    end
  end
endmodule

module regfile_mp_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int DBG_ADDR   = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic                           iss_en,
  input  logic [ADDR_WIDTH-1:0]          iss_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic [ADDR_WIDTH:0]            busy_cnt,
  output logic [DATA_WIDTH-1:0]          dbg_data
);
  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] NREGS_L = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 busy;
  logic [NUM_REGS-1:0]                 busy_nxt;
  logic [ADDR_WIDTH:0]                 cnt_nxt;
  logic                                wr_ok;
  logic                                iss_ok;

  // Only nonzero, in-range destinations touch storage or the scoreboard.
  assign wr_ok  = wr_en  && (wr_addr  != '0) && ({1'b0, wr_addr}  < NREGS_L);
  assign iss_ok = iss_en && (iss_addr != '0) && ({1'b0, iss_addr} < NREGS_L);

  // Scoreboard next state: writeback clears, issue sets; set applied last so
  // a new producer to the same register supersedes the retiring one.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok  && (wr_addr  == ADDR_WIDTH'(i))) busy_nxt[i] = 1'b0;
      if (iss_ok && (iss_addr == ADDR_WIDTH'(i))) busy_nxt[i] = 1'b1;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[i]);
    end
  end

  // Storage, busy bits and busy count; reset wins over any write or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_ok && (wr_addr == ADDR_WIDTH'(i))) begin
          for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) regs[i][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_mp_sb_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
    ) u_rd (
      .addr    (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .regs    (regs),
      .busy    (busy),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_be   (wr_be),
      .data    (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .bsy     (rd_busy[p])
    );
  end

  // Debug tap reads storage directly, so a write shows up one cycle later.
  if (DBG_ADDR < NUM_REGS) begin : g_dbg
    assign dbg_data = regs[DBG_ADDR];
  end else begin : g_dbg_none
    assign dbg_data = '0;
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed plus randomized bench for regfile_mp_sb against an array model.
module tb_regfile_mp_sb;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 24;
  localparam int NRD = 3;
  localparam int DBG = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_be;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [AW:0]       busy_cnt;
  logic [DW-1:0]     dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_reg  [NR];
  bit            m_busy [NR];
  int            ra     [NRD];

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .NUM_RD     (NRD),
    .DBG_ADDR   (DBG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt),
    .dbg_data (dbg_data)
  );

  function automatic bit vld(int a);
    return (a > 0) && (a < NR);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(bit r, bit we, int wa, logic [31:0] wd, logic [3:0] be, bit ie, int ia);
    rst      = r;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    wr_be    = be;
    iss_en   = ie;
    iss_addr = AW'(ia);
    for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'(ra[p]);
  endtask

  task automatic idle();
    drv(0, 0, 0, 32'h0, 4'h0, 0, 0);
  endtask

  // One clock: check combinational reads, advance the model at the edge,
  // then check registered outputs.
  task automatic run_cycle();
    int cnt;
    #1;
    for (int p = 0; p < NRD; p++) begin
      logic [31:0] ed;
      bit          eb;
      int          a;
      a = ra[p];
      if (!vld(a)) begin
        ed = '0; eb = 0;
      end else if (wr_en && int'(wr_addr) == a) begin
        ed = merge(m_reg[a], wr_data, wr_be); eb = 0;
      end else begin
        ed = m_reg[a]; eb = m_busy[a];
      end
      chk($sformatf("rd_data[%0d]@%0d", p, a), rd_data[p*DW +: DW], ed);
      chk($sformatf("rd_busy[%0d]@%0d", p, a), 32'(rd_busy[p]), 32'(eb));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    end else begin
      if (wr_en && vld(int'(wr_addr))) begin
        m_reg[wr_addr]  = merge(m_reg[wr_addr], wr_data, wr_be);
        m_busy[wr_addr] = 0;
      end
      if (iss_en && vld(int'(iss_addr))) m_busy[iss_addr] = 1;
    end
    cnt = 0;
    for (int i = 0; i < NR; i++) cnt += int'(m_busy[i]);
    #1;
    chk("busy_cnt", 32'(busy_cnt), 32'(cnt));
    chk("dbg_data", dbg_data, m_reg[DBG]);
    @(negedge clk);
  endtask

  initial begin
    for (int p = 0; p < NRD; p++) ra[p] = 0;
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    drv(1, 0, 0, 32'h0, 4'h0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    run_cycle();

    // Reset state across every address, including out-of-range ones.
    idle();
    chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    for (int a = 0; a < 32; a += NRD) begin
      for (int p = 0; p < NRD; p++) ra[p] = (a + p) % 32;
      idle();
      run_cycle();
    end

    // Full-word write with same-cycle bypass.
    ra[0] = 5; ra[1] = 0; ra[2] = 5;
    drv(0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0);
    #1 chk("byp_x5", rd_data[31:0], 32'hDEADBEEF);
    run_cycle();
    idle();
    #1 chk("stored_x5", rd_data[31:0], 32'hDEADBEEF);
    run_cycle();

    // Byte-enabled merge, bypass and storage.
    ra[1] = 7;
    drv(0, 1, 7, 32'h11223344, 4'hF, 0, 0);
    run_cycle();
    drv(0, 1, 7, 32'hAABBCCDD, 4'b0101, 0, 0);
    #1 chk("byp_x7_merge", rd_data[DW +: DW], 32'h11BB33DD);
    run_cycle();
    idle();
    #1 chk("stored_x7_merge", rd_data[DW +: DW], 32'h11BB33DD);
    run_cycle();

    // x0 ignores writes and issues.
    ra[0] = 0;
    drv(0, 1, 0, 32'hFFFFFFFF, 4'hF, 1, 0);
    #1 chk("x0_byp", rd_data[31:0], 32'h0);
    run_cycle();
    idle();
    chk("x0_cnt", 32'(busy_cnt), 32'h0);
    run_cycle();

    // Out-of-range write/issue ignored.
    ra[2] = 25;
    drv(0, 1, 25, 32'hCAFEF00D, 4'hF, 1, 25);
    #1 chk("oor_byp", rd_data[2*DW +: DW], 32'h0);
    run_cycle();
    chk("oor_cnt", 32'(busy_cnt), 32'h0);

    // Scoreboard sequence.
    drv(0, 0, 0, 32'h0, 4'h0, 1, 3); run_cycle();
    drv(0, 0, 0, 32'h0, 4'h0, 1, 4); run_cycle();
    chk("sb_cnt2", 32'(busy_cnt), 32'd2);
    ra[0] = 3;
    idle();
    #1 chk("sb_x3_busy", 32'(rd_busy[0]), 32'h1);
    run_cycle();
    drv(0, 1, 3, 32'h00000033, 4'hF, 0, 0);
    #1 chk("sb_x3_wb_byp", 32'(rd_busy[0]), 32'h0);
    run_cycle();
    chk("sb_cnt1", 32'(busy_cnt), 32'd1);
    ra[0] = 4;
    drv(0, 1, 4, 32'h00000044, 4'hF, 1, 4); run_cycle();
    chk("sb_same_cnt", 32'(busy_cnt), 32'd1);
    idle();
    #1 chk("sb_x4_still_busy", 32'(rd_busy[0]), 32'h1);
    run_cycle();
    // Same-cycle issue does not show on rd_busy.
    ra[1] = 9;
    drv(0, 0, 0, 32'h0, 4'h0, 1, 9);
    #1 chk("iss_no_fwd", 32'(rd_busy[1]), 32'h0);
    run_cycle();

    // Debug tap and reset with pending entries.
    drv(0, 0, 0, 32'h0, 4'h0, 1, 1);  run_cycle();
    drv(0, 0, 0, 32'h0, 4'h0, 1, 2);  run_cycle();
    drv(0, 0, 0, 32'h0, 4'h0, 1, 20); run_cycle();
    drv(0, 1, 20, 32'h00000055, 4'hF, 0, 0);
    #1 chk("dbg_no_byp", dbg_data, 32'h0);
    run_cycle();
    chk("dbg_x20", dbg_data, 32'h55);
    drv(1, 1, 5, 32'h12345678, 4'hF, 1, 6); run_cycle();
    chk("rst_mid_cnt", 32'(busy_cnt), 32'h0);
    chk("rst_mid_dbg", dbg_data, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NRD; p++) ra[p] = ($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'($urandom_range(0, 31));
      drv(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
          4'($urandom), $urandom_range(0, 1), $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) iss_addr = wr_addr;
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised next-generation integer register file for the RISC-V core, sitting between decode/issue and writeback.
- Adds a configurable number of read ports, byte-enabled writes, and x0 hardwired to zero.
- Adds same-cycle write-to-read bypass and a per-register pending-write scoreboard with a busy counter, for hazard detection by the issue stage.

Parameters:
DATA_WIDTH, 32, bits per register; must be a multiple of 8
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, register count; must be <= 2**ADDR_WIDTH
NUM_RD, 2, number of read ports, 1..4
DBG_ADDR, 20, register index driven onto dbg_data

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
wr_en  in  1  writeback write strobe
wr_addr  in  ADDR_WIDTH  writeback destination
wr_data  in  DATA_WIDTH  writeback data
wr_be  in  DATA_WIDTH/8  byte enables; bit k covers bits [8k+7:8k]
iss_en  in  1  issue strobe; marks iss_addr pending
iss_addr  in  ADDR_WIDTH  destination of the issued instruction
rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p is slice p
rd_data  out  NUM_RD*DATA_WIDTH  packed read data, combinational
rd_busy  out  NUM_RD  per-port pending flag, combinational
busy_cnt  out  ADDR_WIDTH+1  registered count of pending registers
dbg_data  out  DATA_WIDTH  contents of register DBG_ADDR (no bypass)

Behaviour:
- Reset, when rst=1 at a posedge:
  - all registers become 0, all busy bits become 0, busy_cnt becomes 0.
  - rst overrides wr_en and iss_en in that cycle, including mid-operation with entries pending.
- Write, at posedge with wr_en=1, wr_addr!=0 and wr_addr<NUM_REGS:
  - each byte with wr_be[k]=1 takes wr_data's byte; bytes with wr_be=0 keep their value.
  - wr_be=0 leaves the data unchanged but still clears busy.
- Register 0:
  - reads always return 0 with rd_busy=0.
  - writes and issues to address 0 are ignored.
  - addresses >= NUM_REGS read as 0 with busy=0; writes and issues to them are ignored.
- Scoreboard:
  - at posedge, wr_en to a valid nonzero address clears busy[wr_addr].
  - iss_en to a valid nonzero address sets busy[iss_addr].
  - Same address in the same cycle: set wins, because the new producer supersedes the old.
  - Issue to an already busy register keeps it busy; there is no depth count per register.
  - Write to a non-busy register is legal and leaves busy at 0.
- busy_cnt equals the popcount of the busy vector after the edge update, so it lags the busy bits by 0 cycles relative to their registered state.
- Read port p, combinational:
  - If wr_en=1, wr_addr==rd_addr[p] and the address is valid and nonzero, then rd_data[p] is the byte merge of the stored value and wr_data under wr_be (bypass), and rd_busy[p]=0.
  - Otherwise rd_data[p] is the stored value and rd_busy[p] is busy[rd_addr[p]].
  - A same-cycle iss_en never affects rd_busy; it takes effect the next cycle.
- Multiple read ports may share an address; each resolves independently and identically.
- dbg_data is the registered contents of DBG_ADDR with no bypass; the new value appears the cycle after the write.
- Latency:
  - reads have 0 cycles of latency.
  - writes, scoreboard updates and busy_cnt are visible from storage 1 cycle after the edge.

Test Plan:
- Reset then read all ports at addresses 0..31 -> every rd_data=0, rd_busy=0, busy_cnt=0, dbg_data=0.
- Write 0xDEADBEEF to x5 with wr_be=4'hF while rd_addr port0=5 in the same cycle -> rd_data0=0xDEADBEEF bypassed that cycle; after the edge, stored value is 0xDEADBEEF.
- x7=0x11223344, then write 0xAABBCCDD with wr_be=4'b0101 -> x7=0x11BB33DD; bypass data during that cycle is also 0x11BB33DD.
- Write 0xFFFFFFFF to x0, and issue to x0 -> reads of x0 return 0, busy_cnt stays 0.
- Scoreboard sequence:
  - issue x3, then x4 -> busy_cnt=2, rd_busy=1 for port reading x3.
  - writeback x3 -> same-cycle rd_busy=0 via bypass, busy_cnt=1 next cycle.
  - same cycle iss_en x4 and wr_en x4 -> x4 stays busy, busy_cnt=1.
- Issue x1, x2, x20 and write x20=0x55 -> dbg_data=0x55 one cycle after the write; assert rst -> next cycle all busy cleared, busy_cnt=0, dbg_data=0.
